// File: rtl/pkt_framer_tx.sv
// Packet framer: emits head, len data beats and tail per accepted request,
// with downstream hold, back-to-back packets and a completed-packet counter.
module pkt_framer_tx #(
    parameter int unsigned LEN_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             hold,
    output logic             start_ready,
    output logic             valid,
    output logic             head,
    output logic             tail,
    output logic             done,
    output logic [CNT_W-1:0] pkt_count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HEAD = 2'b01,
        DATA = 2'b10,
        TAIL = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        accept  = start & start_ready;
        state_d = state_q;
        rem_d   = rem_q;
        done_d  = tail;
        cnt_d   = cnt_q + CNT_W'(tail);
        if (accept) begin
            rem_d = len;
        end
        unique case (state_q)
            IDLE: if (accept) state_d = HEAD;
            HEAD: if (valid) state_d = (rem_q != '0) ? DATA : TAIL;
            DATA: begin
                if (valid) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = TAIL;
                end
            end
            TAIL: if (valid) state_d = accept ? HEAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid       = (state_q != IDLE) & ~hold;
        head        = valid & (state_q == HEAD);
        tail        = valid & (state_q == TAIL);
        start_ready = (state_q == IDLE) | ((state_q == TAIL) & ~hold);
        done        = done_q;
        pkt_count   = cnt_q;
    end

endmodule

// File: tb/tb_pkt_framer_tx.sv
// Self-checking bench for pkt_framer_tx: beat-queue reference model plus
// directed literal scenarios and randomized traffic with holds and resets.
module tb_pkt_framer_tx;

    localparam int unsigned LEN_W = 4;
    localparam int unsigned CNT_W = 8;
    localparam byte BH = 8'd1;
    localparam byte BD = 8'd2;
    localparam byte BT = 8'd3;

    logic             clock;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             hold;
    logic             start_ready;
    logic             valid;
    logic             head;
    logic             tail;
    logic             done;
    logic [CNT_W-1:0] pkt_count;

    int checks   = 0;
    int failures = 0;

    pkt_framer_tx #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .len         (len),
        .hold        (hold),
        .start_ready (start_ready),
        .valid       (valid),
        .head        (head),
        .tail        (tail),
        .done        (done),
        .pkt_count   (pkt_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: queue of beats still to be presented for the current packet.
    byte q[$];
    int  m_cnt  = 0;
    bit  m_done = 1'b0;

    initial begin
        bit ev, eh, et, esr;
        forever begin
            @(negedge clock);
            if (!reset) begin
                q.delete();
                m_cnt  = 0;
                m_done = 1'b0;
                check("rst.valid", 32'(valid), 0);
                check("rst.head", 32'(head), 0);
                check("rst.tail", 32'(tail), 0);
                check("rst.start_ready", 32'(start_ready), 1);
                check("rst.done", 32'(done), 0);
                check("rst.pkt_count", 32'(pkt_count), 0);
            end else begin
                ev  = (q.size() != 0) && !hold;
                eh  = ev && (q[0] == BH);
                et  = ev && (q[0] == BT);
                esr = (q.size() == 0) || ((q[0] == BT) && !hold);
                check("mdl.valid", 32'(valid), 32'(ev));
                check("mdl.head", 32'(head), 32'(eh));
                check("mdl.tail", 32'(tail), 32'(et));
                check("mdl.start_ready", 32'(start_ready), 32'(esr));
                check("mdl.done", 32'(done), 32'(m_done));
                check("mdl.pkt_count", 32'(pkt_count), 32'(m_cnt % 256));
                m_done = et;
                if (et) m_cnt++;
                if (ev) void'(q.pop_front());
                if (start && esr) begin
                    q.push_back(BH);
                    for (int i = 0; i < int'(len); i++) q.push_back(BD);
                    q.push_back(BT);
                end
            end
        end
    end

    task automatic step(input logic s, input logic [LEN_W-1:0] l, input logic h);
        @(posedge clock);
        #1;
        start = s;
        len   = l;
        hold  = h;
    endtask

    task automatic chk(input string nm, input logic v, input logic h, input logic t,
                       input logic d, input logic sr);
        @(negedge clock);
        #1;
        check({nm, ".valid"}, 32'(valid), 32'(v));
        check({nm, ".head"}, 32'(head), 32'(h));
        check({nm, ".tail"}, 32'(tail), 32'(t));
        check({nm, ".done"}, 32'(done), 32'(d));
        check({nm, ".start_ready"}, 32'(start_ready), 32'(sr));
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int acc, pulses;
        reset = 1'b0;
        start = 1'b0;
        len   = '0;
        hold  = 1'b0;
        #2;
        check("por.valid", 32'(valid), 0);
        check("por.start_ready", 32'(start_ready), 1);
        check("por.pkt_count", 32'(pkt_count), 0);
        do_reset();

        // len=3: head, 3 data, tail, then done
        step(1, 3, 0); chk("l3.c0", 0, 0, 0, 0, 1);
        step(0, 0, 0); chk("l3.c1", 1, 1, 0, 0, 0);
        step(0, 0, 0); chk("l3.c2", 1, 0, 0, 0, 0);
        step(0, 0, 0); chk("l3.c3", 1, 0, 0, 0, 0);
        step(0, 0, 0); chk("l3.c4", 1, 0, 0, 0, 0);
        step(0, 0, 0); chk("l3.c5", 1, 0, 1, 0, 1);
        step(0, 0, 0); chk("l3.c6", 0, 0, 0, 1, 1);
        check("l3.pkt_count", 32'(pkt_count), 1);
        check("l3.model_cnt", 32'(m_cnt), 1);

        // len=0: head then tail
        step(1, 0, 0); chk("l0.c0", 0, 0, 0, 0, 1);
        step(0, 0, 0); chk("l0.c1", 1, 1, 0, 0, 0);
        step(0, 0, 0); chk("l0.c2", 1, 0, 1, 0, 1);
        step(0, 0, 0); chk("l0.c3", 0, 0, 0, 1, 1);
        check("l0.pkt_count", 32'(pkt_count), 2);

        // len=2 with hold on the first data beat
        step(1, 2, 0); chk("hd.c0", 0, 0, 0, 0, 1);
        step(0, 0, 0); chk("hd.c1", 1, 1, 0, 0, 0);
        step(0, 0, 1); chk("hd.c2", 0, 0, 0, 0, 0);
        step(0, 0, 1); chk("hd.c3", 0, 0, 0, 0, 0);
        step(0, 0, 0); chk("hd.c4", 1, 0, 0, 0, 0);
        step(0, 0, 0); chk("hd.c5", 1, 0, 0, 0, 0);
        step(0, 0, 1); chk("hd.c6", 0, 0, 0, 0, 0);
        step(0, 0, 0); chk("hd.c7", 1, 0, 1, 0, 1);
        step(0, 0, 0); chk("hd.c8", 0, 0, 0, 1, 1);
        check("hd.pkt_count", 32'(pkt_count), 3);

        // start held across tail: back-to-back packets, len=1
        step(1, 1, 0); chk("bb.c0", 0, 0, 0, 0, 1);
        step(1, 1, 0); chk("bb.c1", 1, 1, 0, 0, 0);
        step(1, 1, 0); chk("bb.c2", 1, 0, 0, 0, 0);
        step(1, 1, 0); chk("bb.c3", 1, 0, 1, 0, 1);
        step(1, 1, 0); chk("bb.c4", 1, 1, 0, 1, 0);
        step(1, 1, 0); chk("bb.c5", 1, 0, 0, 0, 0);
        step(0, 1, 0); chk("bb.c6", 1, 0, 1, 0, 1);
        step(0, 0, 0); chk("bb.c7", 0, 0, 0, 1, 1);
        check("bb.pkt_count", 32'(pkt_count), 5);

        // max length: 15 data beats
        step(1, 15, 0); chk("mx.c0", 0, 0, 0, 0, 1);
        step(0, 0, 0);  chk("mx.head", 1, 1, 0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 0); chk("mx.data", 1, 0, 0, 0, 0);
        end
        step(0, 0, 0); chk("mx.tail", 1, 0, 1, 0, 1);
        step(0, 0, 0); chk("mx.done", 0, 0, 0, 1, 1);

        // reset during data of a len=5 packet
        step(1, 5, 0); chk("ra.c0", 0, 0, 0, 0, 1);
        step(0, 0, 0); chk("ra.c1", 1, 1, 0, 0, 0);
        step(0, 0, 0); chk("ra.c2", 1, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("ra.valid_now", 32'(valid), 0);
        check("ra.pkt_count_now", 32'(pkt_count), 0);
        check("ra.start_ready_now", 32'(start_ready), 1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        chk("ra.p0", 0, 0, 0, 0, 1);
        step(0, 0, 0); chk("ra.p1", 0, 0, 0, 0, 1);
        step(1, 1, 0); chk("ra.n0", 0, 0, 0, 0, 1);
        step(0, 0, 0); chk("ra.n1", 1, 1, 0, 0, 0);
        step(0, 0, 0); chk("ra.n2", 1, 0, 0, 0, 0);
        step(0, 0, 0); chk("ra.n3", 1, 0, 1, 0, 1);
        step(0, 0, 0); chk("ra.n4", 0, 0, 0, 1, 1);
        check("ra.pkt_count", 32'(pkt_count), 1);

        // 256 zero-length packets wrap the counter
        do_reset();
        acc    = 0;
        pulses = 0;
        for (int c = 0; c < 600; c++) begin
            step((acc < 256) ? 1'b1 : 1'b0, 0, 0);
            @(negedge clock);
            #1;
            if (done) pulses++;
            if (start && start_ready) acc++;
        end
        check("wrap.accepts", 32'(acc), 256);
        check("wrap.done_pulses", 32'(pulses), 256);
        check("wrap.pkt_count", 32'(pkt_count), 0);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(posedge clock);
            #1;
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 299) == 0) reset = 1'b0;
            start = ($urandom_range(0, 1) == 1);
            len   = LEN_W'($urandom_range(0, 15));
            hold  = ($urandom_range(0, 3) == 0);
        end
        step(0, 0, 0);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
